// File: rtl/seg7_scan_driver.sv
//============================================================================
// Module  : seg7_scan_driver
// Brief   : Time-multiplexed 4-digit common-anode 7-segment scanner with
//           frame-synchronous shadow latch and leading-zero blanking.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module seg7_scan_driver #(
   parameter int SCAN_DIV       = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic        c,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic        lz_blank,
   output logic [0:6]  seg,
   output logic [0:3]  an,
   output logic        frame
);

   localparam int             c_pw      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_pw-1:0] c_last   = c_pw'(SCAN_DIV - 1);
   localparam logic [0:6]     c_seg_off = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
   localparam logic [0:3]     c_an_off  = AN_ACTIVE_LOW  ? 4'b1111    : 4'b0000;

   logic [c_pw-1:0] r_presc;
   logic [1:0]      r_idx;
   logic [15:0]     r_shadow;
   logic            r_lz;
   logic            r_load_pending;

   logic            w_tick;
   logic            w_load;
   logic [3:0]      w_nib;
   logic            w_upper_zero;
   logic            w_blank;
   logic [0:6]      w_pat;
   logic [0:6]      w_seg_n;
   logic [0:6]      w_seg;
   logic [0:3]      w_an_n;
   logic [0:3]      w_an;

   assign w_tick = (r_presc == c_last);
   // Reloading only at the 3->0 wrap keeps every frame from a single value.
   assign w_load = (w_tick && (r_idx == 2'd3)) || r_load_pending;

   always_comb begin
      w_nib        = r_shadow[{r_idx, 2'b00} +: 4];
      w_upper_zero = 1'b0;
      case (r_idx)
         2'd3:    w_upper_zero = (r_shadow[15:12] == 4'h0);
         2'd2:    w_upper_zero = (r_shadow[15:8]  == 8'h00);
         2'd1:    w_upper_zero = (r_shadow[15:4]  == 12'h000);
         default: w_upper_zero = 1'b0;
      endcase
      w_blank = r_lz && w_upper_zero;

      w_pat = 7'b1111111;
      case (w_nib)
         4'h0:    w_pat = 7'b0000001;
         4'h1:    w_pat = 7'b1001111;
         4'h2:    w_pat = 7'b0010010;
         4'h3:    w_pat = 7'b0000110;
         4'h4:    w_pat = 7'b1001100;
         4'h5:    w_pat = 7'b0100100;
         4'h6:    w_pat = 7'b0100000;
         4'h7:    w_pat = 7'b0001111;
         4'h8:    w_pat = 7'b0000000;
         4'h9:    w_pat = 7'b0000100;
         4'hA:    w_pat = 7'b0001000;
         4'hB:    w_pat = 7'b1100000;
         4'hC:    w_pat = 7'b0110001;
         4'hD:    w_pat = 7'b1000010;
         4'hE:    w_pat = 7'b0110000;
         default: w_pat = 7'b0111000;
      endcase

      w_seg_n        = w_blank ? 7'b1111111 : w_pat;
      w_seg          = SEG_ACTIVE_LOW ? w_seg_n : ~w_seg_n;
      w_an_n         = 4'b1111;
      w_an_n[r_idx]  = 1'b0;
      w_an           = AN_ACTIVE_LOW ? w_an_n : ~w_an_n;
   end

   always_ff @(posedge c) begin
      if (rst) begin
         r_presc        <= '0;
         r_idx          <= 2'd0;
         r_shadow       <= 16'h0000;
         r_lz           <= 1'b0;
         r_load_pending <= 1'b1;
         frame          <= 1'b0;
         seg            <= c_seg_off;
         an             <= c_an_off;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + c_pw'(1);
         if (w_tick) begin
            r_idx <= r_idx + 2'd1;
         end
         if (w_load) begin
            r_shadow <= value;
            r_lz     <= lz_blank;
         end
         r_load_pending <= 1'b0;
         frame          <= w_load;
         seg            <= w_seg;
         an             <= w_an;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
//============================================================================
// Module  : tb_seg7_scan_driver
// Brief   : Randomized self-checking bench for seg7_scan_driver (both polarities).
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_seg7_scan_driver;

   localparam int D = 4;

   logic        c = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] value = 16'h0000;
   logic        lz_blank = 1'b0;
   logic [0:6]  seg, seg_p;
   logic [0:3]  an, an_p;
   logic        frame, frame_p;

   int checks = 0;
   int errors = 0;

   // Reference state: cycles since reset release, and the latched frame value.
   int          n = 0;
   logic [15:0] m_shadow = 16'h0000;
   logic        m_lz = 1'b0;
   logic [0:6]  exp_seg = 7'b1111111;
   logic [0:3]  exp_an = 4'b1111;
   logic        exp_frame = 1'b0;

   logic [0:6] hex_tbl [0:15] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   seg7_scan_driver #(.SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
      .c(c), .rst(rst), .value(value), .lz_blank(lz_blank),
      .seg(seg), .an(an), .frame(frame));

   seg7_scan_driver #(.SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_p (
      .c(c), .rst(rst), .value(value), .lz_blank(lz_blank),
      .seg(seg_p), .an(an_p), .frame(frame_p));

   always #5 c = ~c;

   // Digit shown next is ((n)/D)%4; the output after edge n shows digit ((n-1)/D)%4.
   function automatic int next_digit();
      return (n / D) % 4;
   endfunction

   task automatic step();
      logic        r_s;
      logic [15:0] v_s;
      logic        lz_s;
      int          d;
      logic [3:0]  nib;
      r_s  = rst;
      v_s  = value;
      lz_s = lz_blank;
      @(posedge c);
      if (r_s) begin
         n = 0; m_shadow = 16'h0000; m_lz = 1'b0;
         exp_seg = 7'b1111111; exp_an = 4'b1111; exp_frame = 1'b0;
      end else begin
         n++;
         d   = ((n - 1) / D) % 4;
         nib = m_shadow[4*d +: 4];
         if (m_lz && d != 0 && (m_shadow >> (4*d)) == 16'h0000) exp_seg = 7'b1111111;
         else exp_seg = hex_tbl[nib];
         exp_an    = 4'b1111;
         exp_an[d] = 1'b0;
         exp_frame = (n == 1) || (n % (4*D) == 0);
         if (exp_frame) begin
            m_shadow = v_s;
            m_lz     = lz_s;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; value = 16'h0000; lz_blank = 1'b0;
      repeat (3) step();
      checks++;
      if ({seg, an, frame} !== {7'b1111111, 4'b1111, 1'b0}) begin
         errors++; $display("FAIL reset_state got=%b exp=%b", {seg, an, frame}, {7'b1111111, 4'b1111, 1'b0});
      end
      checks++;
      if ({seg_p, an_p, frame_p} !== {7'b0000000, 4'b0000, 1'b0}) begin
         errors++; $display("FAIL reset_state_pol got=%b exp=%b", {seg_p, an_p, frame_p}, 12'b0);
      end
      rst = 1'b0;
      step();
      checks++;
      if (frame !== 1'b1) begin
         errors++; $display("FAIL reset_first_frame got=%b exp=1", frame);
      end
      step();
      checks++;
      if ({seg, an, frame} !== {7'b0000001, 4'b0111, 1'b0}) begin
         errors++; $display("FAIL reset_first_digit got=%b exp=%b", {seg, an, frame}, {7'b0000001, 4'b0111, 1'b0});
      end
   endtask

   task automatic test_scan();
      rst = 1'b1; step(); rst = 1'b0;
      value = 16'h1234; lz_blank = 1'b0;
      repeat (40) begin
         step();
         checks++;
         if ({seg, an, frame} !== {exp_seg, exp_an, exp_frame}) begin
            errors++; $display("FAIL scan n=%0d got=%b exp=%b", n, {seg, an, frame}, {exp_seg, exp_an, exp_frame});
         end
         checks++;
         if ({seg_p, an_p, frame_p} !== {~exp_seg, ~exp_an, exp_frame}) begin
            errors++; $display("FAIL scan_pol n=%0d got=%b exp=%b", n, {seg_p, an_p, frame_p}, {~exp_seg, ~exp_an, exp_frame});
         end
      end
   endtask

   task automatic test_frame_sync();
      int guard = 0;
      while (next_digit() != 1 && guard < 40) begin
         step(); guard++;
      end
      checks++;
      if (guard >= 40) begin
         errors++; $display("FAIL frame_sync_wait got=timeout exp=digit1");
      end
      value = 16'hABCD;
      repeat (40) begin
         step();
         checks++;
         if ({seg, an, frame} !== {exp_seg, exp_an, exp_frame}) begin
            errors++; $display("FAIL frame_sync n=%0d got=%b exp=%b", n, {seg, an, frame}, {exp_seg, exp_an, exp_frame});
         end
      end
   endtask

   task automatic test_lz_blank();
      logic [15:0] vals [3] = '{16'h0050, 16'h0000, 16'h0000};
      logic        lzs  [3] = '{1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 3; k++) begin
         value = vals[k]; lz_blank = lzs[k];
         repeat (36) begin
            step();
            checks++;
            if ({seg, an, frame} !== {exp_seg, exp_an, exp_frame}) begin
               errors++; $display("FAIL lz_blank case=%0d n=%0d got=%b exp=%b", k, n, {seg, an, frame}, {exp_seg, exp_an, exp_frame});
            end
            checks++;
            if ({seg_p, an_p, frame_p} !== {~exp_seg, ~exp_an, exp_frame}) begin
               errors++; $display("FAIL lz_blank_pol case=%0d n=%0d got=%b exp=%b", k, n, {seg_p, an_p, frame_p}, {~exp_seg, ~exp_an, exp_frame});
            end
         end
      end
   endtask

   task automatic test_reset_midscan();
      int guard = 0;
      value = 16'h5A3C; lz_blank = 1'b0;
      while (next_digit() != 2 && guard < 40) begin
         step(); guard++;
      end
      checks++;
      if (guard >= 40) begin
         errors++; $display("FAIL midscan_wait got=timeout exp=digit2");
      end
      rst = 1'b1;
      step();
      checks++;
      if ({seg, an, frame} !== {7'b1111111, 4'b1111, 1'b0}) begin
         errors++; $display("FAIL midscan_reset got=%b exp=%b", {seg, an, frame}, {7'b1111111, 4'b1111, 1'b0});
      end
      rst = 1'b0;
      value = 16'hE07F;
      repeat (24) begin
         step();
         checks++;
         if ({seg, an, frame} !== {exp_seg, exp_an, exp_frame}) begin
            errors++; $display("FAIL midscan n=%0d got=%b exp=%b", n, {seg, an, frame}, {exp_seg, exp_an, exp_frame});
         end
      end
   endtask

   task automatic test_polarity();
      value = 16'h0008; lz_blank = 1'b0;
      repeat (36) begin
         step();
         if (n > 4*D && exp_an == 4'b0111) begin
            checks++;
            if ({seg_p, an_p} !== {7'b1111111, 4'b1000}) begin
               errors++; $display("FAIL polarity_digit0 n=%0d got=%b exp=%b", n, {seg_p, an_p}, {7'b1111111, 4'b1000});
            end
         end
         checks++;
         if ({seg_p, an_p, frame_p} !== {~exp_seg, ~exp_an, exp_frame}) begin
            errors++; $display("FAIL polarity n=%0d got=%b exp=%b", n, {seg_p, an_p, frame_p}, {~exp_seg, ~exp_an, exp_frame});
         end
      end
   endtask

   task automatic test_random();
      repeat (500) begin
         if ($urandom_range(0, 7) == 0) begin
            value    = 16'($urandom);
            lz_blank = 1'($urandom);
         end
         if ($urandom_range(0, 5) == 0) value[15:8] = 8'h00;
         rst = ($urandom_range(0, 99) == 0);
         step();
         checks++;
         if ({seg, an, frame} !== {exp_seg, exp_an, exp_frame}) begin
            errors++; $display("FAIL random n=%0d got=%b exp=%b", n, {seg, an, frame}, {exp_seg, exp_an, exp_frame});
         end
         checks++;
         if ({seg_p, an_p, frame_p} !== {~exp_seg, ~exp_an, exp_frame}) begin
            errors++; $display("FAIL random_pol n=%0d got=%b exp=%b", n, {seg_p, an_p, frame_p}, {~exp_seg, ~exp_an, exp_frame});
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_scan();
      test_frame_sync();
      test_lz_blank();
      test_reset_midscan();
      test_polarity();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Display-side consumer of the 4-bit up/down counter outputs.
- Takes a 16-bit value (four hex nibbles, one per counter) and time-multiplexes it onto a 4-digit common-anode 7-segment display.
- Outputs use the segment bus format seg[0:6] and a digit-enable bus.
- Refresh prescaler, digit scan counter, frame-synchronous shadow latch and optional leading-zero blanking.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays lit; legal range 2..2^20.
- SEG_ACTIVE_LOW, 1: 1 means segment lit = 0; 0 inverts seg polarity.
- AN_ACTIVE_LOW, 1: 1 means digit enabled = 0; 0 inverts an polarity.

Ports:
- c  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  16  display value; value[3:0] is digit 0 (rightmost), value[15:12] is digit 3.
- lz_blank  input  1  1 = suppress leading zeros; sampled with value at frame start.
- seg  output  [0:6]  segments a..g; seg[0]=a, seg[6]=g; registered.
- an  output  [0:3]  digit enables; an[0]=digit 0 (rightmost); registered; one-hot active.
- frame  output  1  one-cycle pulse when a new shadow value is latched; registered.

Behaviour:
- Reset, sampled on c rising edge while rst=1:
  - prescaler=0, digit index=0, shadow=0, shadow lz flag=0, load_pending=1, frame=0.
  - seg all off (7'b1111111 when SEG_ACTIVE_LOW=1); an all off (4'b1111 when AN_ACTIVE_LOW=1).
- Reset mid-scan: same result on the next edge; no partial digit is kept.
- Prescaler: counts 0..SCAN_DIV-1 and wraps to 0. tick=1 when prescaler==SCAN_DIV-1.
- Digit index: advances on tick, 0->1->2->3->0.
- Shadow load:
  - Condition: (tick and index==3) or load_pending. Shadow<=value and shadow lz<=lz_blank; load_pending clears.
  - The first non-reset cycle therefore loads shadow. Afterwards loads happen only at frame wrap, so a frame never mixes old and new digits.
  - frame=1 on the cycle after each load.
- Output stage: seg and an are registered from the current index and shadow, with 1 cycle latency. Exactly one an bit is active after the first post-reset cycle; index k drives an[k].
- Decode, hex, active-low a..g: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000. SEG_ACTIVE_LOW=0 inverts each.
- Leading-zero blanking, when shadow lz=1:
  - Digit k (k=3..1) is blank (all segments off, an still scans) if nibbles k..3 are all zero.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- value changes mid-frame are ignored until the next frame boundary. A change on the exact load cycle is captured.
- No other state; no handshake back to the counters.

Test Plan:
- Reset behaviour (SCAN_DIV=4): hold rst=1 for 3 cycles -> seg=1111111, an=1111, frame=0. Release with value=16'h0000 -> one cycle later frame=1. The cycle after that, an=0111 and seg=0000001.
- Scan order (SCAN_DIV=4, value=16'h1234, lz_blank=0) -> an steps 0111, 1011, 1101, 1110 with 4 cycles each, repeating. seg is 1001100 (4), 0000110 (3), 0010010 (2), 1001111 (1) respectively, with 1-cycle lag relative to the index change.
- Frame-synchronous update: change value 16'h1234->16'hABCD while index=1 -> digits 2 and 3 still show 2 and 1 for the rest of the frame. After the index 3->0 wrap, frame pulses and the display shows D, C, b, A (1000010, 0110001, 1100000, 0001000).
- Leading-zero blanking: value=16'h0050, lz_blank=1 -> digit 0 shows 0000001, digit 1 shows 0100100, digits 2 and 3 show 1111111. With value=16'h0000, only digit 0 is lit ("0"). With lz_blank=0, all four digits show 0000001.
- Reset mid-scan: assert rst while index=2 -> next edge seg=1111111, an=1111. After release the scan restarts at digit 0 with a fresh shadow load and a frame pulse.
- Polarity parameters: SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0, value=16'h0008 -> digit 0 has an=1000 and seg=1111111. Reset value is seg=0000000, an=0000.
